// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM state encoding,
// instruction opcode/funct fields, ALU operation class and ALU control codes.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder.
//   aluop      in  2          operation class from the FSM: 00 add, 01 sub, 10 use funct
//   funct      in  6          IR[5:0]
//   alucontrol out ALUCTRL_W  ALU operation code
module alu_decoder
  import mips_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 3
) (
  input  logic [1:0]           aluop,
  input  logic [5:0]           funct,
  output logic [ALUCTRL_W-1:0] alucontrol
);

  logic [2:0] code;

  always_comb begin
    code = ALU_ADD;
    case (aluop)
      ALUOP_SUB:   code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_SUB:  code = ALU_SUB;
          FN_AND:  code = ALU_AND;
          FN_OR:   code = ALU_OR;
          FN_SLT:  code = ALU_SLT;
          default: code = ALU_ADD;  // FN_ADD and unknown funct both add
        endcase
      end
      default:     code = ALU_ADD;
    endcase
  end

  assign alucontrol = ALUCTRL_W'(code);

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing a shared datapath plus
// ALU decoder. Memory-access states can be stretched by mem_ready.
//   clk, reset_n       clock, synchronous active-low reset
//   op, funct, zero    IR fields and ALU zero flag from the datapath
//   mem_ready          memory finished its access this cycle
//   iord..pcsrc        datapath mux selects and write enables
//   alucontrol         ALU operation code
//   pcen               PC write enable (pcwrite | branch & zero)
//   illegal_op         one-cycle pulse in DECODE for an unsupported opcode
//   state_o            current state (debug)
module mips_mc_controller
  import mips_pkg::*;
#(
  parameter int unsigned USE_MEM_READY = 1,
  parameter int unsigned ALUCTRL_W     = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 pcen,
  output logic                 illegal_op,
  output logic [3:0]           state_o
);

  state_t     state, next;
  logic [1:0] aluop;
  logic       pcwrite, branch, mem_ok;

  assign mem_ok  = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
  assign state_o = state;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= next;
  end

  always_comb begin
    next       = S_FETCH;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = ALUOP_ADD;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;

    case (state)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ok;
        pcwrite = mem_ok;
        next    = mem_ok ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: next = S_MEMADR;
          OP_RTYPE:     next = S_RTYPEEX;
          OP_BEQ:       next = S_BEQEX;
          OP_ADDI:      next = S_ADDIEX;
          OP_J:         next = S_JEX;
          default: begin
            next       = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_LW)      next = S_MEMRD;
        else if (op == OP_SW) next = S_MEMWR;
        else                  next = S_FETCH;
      end
      S_MEMRD: begin
        iord = 1'b1;
        next = mem_ok ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        // Write enable stays asserted through the stall; leaving on mem_ready
        // guarantees the store completes exactly once.
        iord     = 1'b1;
        memwrite = 1'b1;
        next     = mem_ok ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        next    = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        next    = S_ADDIWB;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: next = S_FETCH;
    endcase

    pcen = pcwrite | (branch & zero);

    // Reset masks the decode so an interrupted instruction performs no writes.
    if (!reset_n) begin
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      pcen       = 1'b0;
      illegal_op = 1'b0;
    end
  end

  alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule
